uart_rx_sipo: RTL

//  Serial-in/parallel-out UART receive datapath; inverse of the Tx frame serializer.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_bit_sampler.sv | 45 ++++
 rtl/uart_rx_sipo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive datapath.
// Optional build macro RX_MAJORITY_SAMPLE_EN is consumed by uart_rx_bit_sampler.
package uart_rx_pkg;

  localparam int OVS_DEFAULT = 16;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Rx line synchronizer plus bit-value sampler.
// With RX_MAJORITY_SAMPLE_EN defined the sampled bit is a 2-of-3 vote around the sample tick.
module uart_rx_bit_sampler #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic level,
  output logic sample_bit
);

  logic [SYNC_FF-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_FF-2:0], rx};
    end
  end

  assign level = sync_reg[SYNC_FF-1];

`ifdef RX_MAJORITY_SAMPLE_EN
  // The vote uses one tick behind, the current level, and the stage one tick ahead,
  // so the decision stays centred on the same sample tick as the single-sample build.
  logic prev_reg;
  logic ahead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= level;
    end
  end

  assign ahead      = sync_reg[SYNC_FF-2];
  assign sample_bit = (prev_reg & level) | (prev_reg & ahead) | (level & ahead);
`else
  assign sample_bit = level;
`endif

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive serial-in/parallel-out datapath: start detect, LSB-first data, parity, stop.
// Build macro RX_MAJORITY_SAMPLE_EN selects 2-of-3 majority bit sampling.
module uart_rx_sipo
  import uart_rx_pkg::*;
#(
  parameter int OVS     = OVS_DEFAULT,
  parameter int SYNC_FF = 2
) (
  input  logic       BaudOut,
  input  logic       ResetN,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataParl,
  output logic       ActiveFlag,
  output logic       DoneFlag,
  output logic       ParityError,
  output logic       StopError
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);

  logic level;
  logic sample_bit;

  uart_rx_bit_sampler #(.SYNC_FF(SYNC_FF)) u_sampler (
    .clk        (BaudOut),
    .rst_n      (ResetN),
    .rx         (RxIn),
    .level      (level),
    .sample_bit (sample_bit)
  );

  rx_state_e     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic          stop_cnt_reg;
  logic [7:0]    shift_reg;
  logic          par_bit_reg;
  logic          stop_err_reg;
  logic          armed_reg;
  logic [1:0]    cfg_par_reg;
  logic          cfg_stop2_reg;
  logic          cfg_len8_reg;
  logic [7:0]    data_reg;
  logic          active_reg;
  logic          done_reg;
  logic          perr_reg;
  logic          serr_reg;

  logic       bit_tick;
  logic [2:0] last_data;
  logic [7:0] frame_data;
  logic       par_xor;
  logic       par_err;

  assign bit_tick   = (cnt_reg == BIT_LAST);
  assign last_data  = cfg_len8_reg ? 3'd7 : 3'd6;
  // In 7-bit mode the bits were shifted in only seven times, so they sit one place high.
  assign frame_data = cfg_len8_reg ? shift_reg : {1'b0, shift_reg[7:1]};
  assign par_xor    = (^frame_data) ^ par_bit_reg;
  assign par_err    = (cfg_par_reg == PAR_ODD)  ? ~par_xor :
                      (cfg_par_reg == PAR_EVEN) ?  par_xor : 1'b0;

  always_ff @(posedge BaudOut or negedge ResetN) begin
    if (!ResetN) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      stop_cnt_reg  <= 1'b0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      stop_err_reg  <= 1'b0;
      armed_reg     <= 1'b0;
      cfg_par_reg   <= PAR_NONE0;
      cfg_stop2_reg <= 1'b0;
      cfg_len8_reg  <= 1'b0;
      data_reg      <= '0;
      active_reg    <= 1'b0;
      done_reg      <= 1'b0;
      perr_reg      <= 1'b0;
      serr_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // A held-low line (break) must go high once before a new start is accepted.
      if (level) begin
        armed_reg <= 1'b1;
      end

      if (state_reg == ST_DATA || state_reg == ST_PARITY || state_reg == ST_STOP) begin
        cnt_reg <= bit_tick ? '0 : cnt_reg + CW'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (armed_reg && !level) begin
            state_reg     <= ST_START;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            stop_err_reg  <= 1'b0;
            armed_reg     <= 1'b0;
            cfg_par_reg   <= ParityType;
            cfg_stop2_reg <= StopBits;
            cfg_len8_reg  <= DataLength;
          end
        end
        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (sample_bit) begin
              state_reg <= ST_IDLE;
            end else begin
              active_reg <= 1'b1;
              state_reg  <= ST_DATA;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_reg <= {sample_bit, shift_reg[7:1]};
            if (bit_cnt_reg == last_data) begin
              bit_cnt_reg <= '0;
              state_reg   <= parity_enabled(cfg_par_reg) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            par_bit_reg <= sample_bit;
            state_reg   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (!sample_bit) begin
              stop_err_reg <= 1'b1;
            end
            if (cfg_stop2_reg && !stop_cnt_reg) begin
              stop_cnt_reg <= 1'b1;
            end else begin
              state_reg  <= ST_DONE;
              active_reg <= 1'b0;
              done_reg   <= 1'b1;
              data_reg   <= frame_data;
              perr_reg   <= par_err;
              serr_reg   <= stop_err_reg | ~sample_bit;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign DataParl    = data_reg;
  assign ActiveFlag  = active_reg;
  assign DoneFlag    = done_reg;
  assign ParityError = perr_reg;
  assign StopError   = serr_reg;

endmodule
